// File: rtl/jtag_chain_ctrl_if.sv
// Configuration word stream into the JTAG chain controller.
// Handshake: a word transfers on every rising edge where cfg_valid && cfg_ready; cfg_data is held while cfg_valid waits for cfg_ready.
interface jtag_chain_ctrl_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;

    modport master (output cfg_data, output cfg_valid, input cfg_ready);
    modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/jtag_chain_ctrl.sv
// Serialises a tile-enable header plus per-tile payload windows onto a daisy-chained tile config chain.
// Optional macro JTAG_CHAIN_ZERO_FILL_EN: disabled tiles get an all-zero window without consuming words.
module jtag_chain_ctrl #(
    parameter int NUM_TILES = 9,
    parameter int MEM_BITS  = 32768,
    parameter int WORD_W    = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [NUM_TILES-1:0] i_tile_mask,
    jtag_chain_ctrl_if.slave     cfg,
    output logic                 o_chain_rst,
    output logic                 o_chain_data,
    output logic                 o_chain_clk_en,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [1:0]           o_state
);
    localparam int TOTAL_BITS = NUM_TILES * MEM_BITS;
    localparam int PL_W       = $clog2(TOTAL_BITS + 1);
    localparam int BL_W       = $clog2(WORD_W + 1);
    localparam int HC_W       = $clog2(NUM_TILES + 1);

    // r_state names the phase of the bit being prepared for the next cycle,
    // so it leads the registered chain outputs by one cycle.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t               r_state;
    logic [NUM_TILES-1:0] r_hdr_sr;
    logic [HC_W-1:0]      r_hdr_cnt;
    logic [WORD_W-1:0]    r_shift;
    logic [BL_W-1:0]      r_bits_left;
    logic [PL_W-1:0]      r_pay_left;
    logic                 r_chain_rst;
    logic                 r_chain_data;
    logic                 r_clk_en;
    logic                 r_busy;
    logic                 r_done;

    logic w_zero_win;
    logic w_cfg_ready;
    logic w_bit_avail;
    logic w_next_bit;

`ifdef JTAG_CHAIN_ZERO_FILL_EN
    localparam int WIN_W  = (MEM_BITS > 1) ? $clog2(MEM_BITS) : 1;
    localparam int TILE_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

    logic [NUM_TILES-1:0] r_mask;
    logic [TILE_W-1:0]    r_tile;
    logic [WIN_W-1:0]     r_win_cnt;

    assign w_zero_win = ~r_mask[r_tile];
`else
    assign w_zero_win = 1'b0;
`endif

    // Word boundaries coincide with window boundaries, so r_bits_left is zero at every window start.
    assign w_cfg_ready = (r_state == ST_PAYLOAD) && (r_bits_left == '0) && !w_zero_win;
    assign w_bit_avail = w_zero_win || (r_bits_left != '0) || cfg.cfg_valid;
    assign w_next_bit  = w_zero_win ? 1'b0 :
                         (r_bits_left != '0) ? r_shift[WORD_W-1] : cfg.cfg_data[WORD_W-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_hdr_sr     <= '0;
            r_hdr_cnt    <= '0;
            r_shift      <= '0;
            r_bits_left  <= '0;
            r_pay_left   <= '0;
            r_chain_rst  <= 1'b1;
            r_chain_data <= 1'b0;
            r_clk_en     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
`ifdef JTAG_CHAIN_ZERO_FILL_EN
            r_mask       <= '0;
            r_tile       <= '0;
            r_win_cnt    <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    // r_busy is still high during the done cycle, which keeps start ignored there.
                    if (i_start && !r_busy) begin
                        r_chain_rst  <= 1'b0;
                        r_chain_data <= i_tile_mask[0];
                        r_clk_en     <= 1'b1;
                        r_busy       <= 1'b1;
                        r_hdr_sr     <= i_tile_mask >> 1;
                        r_hdr_cnt    <= HC_W'(NUM_TILES - 1);
                        r_shift      <= '0;
                        r_bits_left  <= '0;
                        r_pay_left   <= PL_W'(TOTAL_BITS);
`ifdef JTAG_CHAIN_ZERO_FILL_EN
                        r_mask       <= i_tile_mask;
                        r_tile       <= '0;
                        r_win_cnt    <= '0;
`endif
                        r_state      <= (NUM_TILES == 1) ? ST_PAYLOAD : ST_HEADER;
                    end else begin
                        r_chain_rst  <= 1'b1;
                        r_chain_data <= 1'b0;
                        r_clk_en     <= 1'b0;
                        r_busy       <= 1'b0;
                    end
                end
                ST_HEADER: begin
                    r_chain_data <= r_hdr_sr[0];
                    r_clk_en     <= 1'b1;
                    r_hdr_sr     <= r_hdr_sr >> 1;
                    r_hdr_cnt    <= r_hdr_cnt - 1'b1;
                    if (r_hdr_cnt == HC_W'(1)) begin
                        r_state <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    // A missing word stalls the chain: no qualified clock, data and counters hold.
                    r_clk_en <= w_bit_avail;
                    if (w_bit_avail) begin
                        r_chain_data <= w_next_bit;
                        r_pay_left   <= r_pay_left - 1'b1;
                        if (!w_zero_win) begin
                            if (r_bits_left != '0) begin
                                r_shift     <= r_shift << 1;
                                r_bits_left <= r_bits_left - 1'b1;
                            end else begin
                                r_shift     <= cfg.cfg_data << 1;
                                r_bits_left <= BL_W'(WORD_W - 1);
                            end
                        end
`ifdef JTAG_CHAIN_ZERO_FILL_EN
                        if (r_win_cnt == WIN_W'(MEM_BITS - 1)) begin
                            r_win_cnt <= '0;
                            r_tile    <= r_tile + 1'b1;
                        end else begin
                            r_win_cnt <= r_win_cnt + 1'b1;
                        end
`endif
                        if (r_pay_left == PL_W'(1)) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_clk_en <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cfg.cfg_ready    = w_cfg_ready;
    assign o_chain_rst      = r_chain_rst;
    assign o_chain_data     = r_chain_data;
    assign o_chain_clk_en   = r_clk_en;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_state          = r_state;
endmodule

// File: tb/tb_jtag_chain_ctrl.sv
// Bench for jtag_chain_ctrl: random words/masks checked against a bit-stream model of the chain.
// Honours JTAG_CHAIN_ZERO_FILL_EN in the model when the design is built with it.
`timescale 1ns/1ps
module tb_jtag_chain_ctrl;
    localparam int NT        = 3;
    localparam int MB        = 64;
    localparam int WW        = 32;
    localparam int WPT       = MB / WW;
    localparam int BASE_DONE = 1 + NT + NT * MB;
    localparam int BUDGET    = 600;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [NT-1:0] tile_mask;
    logic o_chain_rst, o_chain_data, o_chain_clk_en, o_busy, o_done;
    logic [1:0] state_dbg;

    always #5 clk = ~clk;

    jtag_chain_ctrl_if #(.WORD_W(WW)) cfg_if ();

    jtag_chain_ctrl #(.NUM_TILES(NT), .MEM_BITS(MB), .WORD_W(WW)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_tile_mask    (tile_mask),
        .cfg            (cfg_if),
        .o_chain_rst    (o_chain_rst),
        .o_chain_data   (o_chain_data),
        .o_chain_clk_en (o_chain_clk_en),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_state        (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [WW-1:0] src_q[$];
    logic [0:0]    exp_q[$];
    logic [0:0]    got_q[$];
    int exp_words;
    int done_cycle, done_count, words_used, gap_cycles, hold_bad, rst_bad, ready_bad;
    int first_en_cycle, rst_seen_bits;
    logic post_chain_rst, post_busy, post_clk_en, post_data, post_done, post_ready;

    // Reference model: header = mask bits LSB first, then each tile window in order,
    // either the next WPT words MSB first or (zero-fill build, tile disabled) MB zeros.
    function automatic void build_expected(input logic [NT-1:0] mask);
        int k;
        bit zero;
        logic [WW-1:0] w;
        exp_q.delete();
        k = 0;
        for (int i = 0; i < NT; i++) exp_q.push_back(mask[i]);
        for (int t = 0; t < NT; t++) begin
            zero = 1'b0;
`ifdef JTAG_CHAIN_ZERO_FILL_EN
            zero = !mask[t];
`endif
            if (zero) begin
                for (int b = 0; b < MB; b++) exp_q.push_back(1'b0);
            end else begin
                for (int j = 0; j < WPT; j++) begin
                    w = src_q[k];
                    k++;
                    for (int b = WW - 1; b >= 0; b--) exp_q.push_back(w[b]);
                end
            end
        end
        exp_words = k;
    endfunction

    function automatic int first_diff();
        int n;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
        if (got_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic new_words(input bit fixed_a5);
        src_q.delete();
        for (int i = 0; i < NT * WPT + 4; i++) src_q.push_back(fixed_a5 ? 32'hA5A5A5A5 : WW'($urandom()));
    endtask

    // ---------------- driver ----------------
    // Cycle 0 is the cycle in which start is accepted; outputs of cycle k are sampled at its negedge.
    task automatic drive_load(input logic [NT-1:0] mask, input int stall_at, input int stall_len,
                              input int rst_at, input int poke_at);
        int cyc;
        int stall_left;
        logic prev_data;
        got_q.delete();
        done_cycle = -1; done_count = 0; words_used = 0; gap_cycles = 0; hold_bad = 0;
        rst_bad = 0; ready_bad = 0; first_en_cycle = -1; rst_seen_bits = -1;
        stall_left = -1;
        prev_data = 1'b0;
        tile_mask = mask;
        start = 1'b1;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_data = src_q[0];
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < BUDGET) begin
            if (o_chain_clk_en === 1'b1) begin
                got_q.push_back(o_chain_data);
                if (first_en_cycle < 0) first_en_cycle = cyc;
            end
            if (o_done === 1'b1) begin
                done_count++;
                if (done_cycle < 0) done_cycle = cyc;
            end
            if (o_busy === 1'b1 && o_done !== 1'b1 && o_chain_clk_en !== 1'b1) begin
                gap_cycles++;
                if (o_chain_data !== prev_data) hold_bad++;
            end
            if (o_busy === 1'b1 && o_chain_rst !== 1'b0) rst_bad++;
            if (cfg_if.cfg_ready === 1'b1 && (o_busy !== 1'b1 || o_done === 1'b1)) ready_bad++;
            if (rst_at >= 0 && cyc == rst_at + 1) begin
                post_chain_rst = o_chain_rst; post_busy = o_busy; post_clk_en = o_chain_clk_en;
                post_data = o_chain_data; post_done = o_done; post_ready = cfg_if.cfg_ready;
                rst_seen_bits = got_q.size();
            end
            prev_data = o_chain_data;
            rst = (rst_at >= 0 && cyc == rst_at);
            start = (poke_at >= 0 && cyc == poke_at);
            if (poke_at >= 0 && cyc >= poke_at) tile_mask = ~mask;
            if (stall_at >= 0 && stall_left < 0 && cyc >= stall_at && cfg_if.cfg_ready === 1'b1)
                stall_left = stall_len;
            if (stall_left > 0) begin
                cfg_if.cfg_valid = 1'b0;
                stall_left--;
            end else begin
                cfg_if.cfg_valid = 1'b1;
            end
            cfg_if.cfg_data = (words_used < src_q.size()) ? src_q[words_used] : WW'($urandom());
            if (cfg_if.cfg_valid && cfg_if.cfg_ready === 1'b1) words_used++;
            if (done_count > 0 && cyc >= done_cycle + 2) break;
            if (rst_at >= 0 && cyc >= rst_at + 6) break;
            @(negedge clk);
            cyc++;
        end
        if (cyc >= BUDGET) $display("FAIL load_timeout: got no completion within %0d cycles, expected done", BUDGET);
        start = 1'b0;
        rst = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        tile_mask = mask;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; tile_mask = '0;
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_data = '0;
        @(negedge clk);
        @(negedge clk);
        n_vec++; if (o_chain_rst !== 1'b1) begin n_err++; $display("FAIL reset_chain_rst: got %b expected 1", o_chain_rst); end
        n_vec++; if (o_chain_data !== 1'b0) begin n_err++; $display("FAIL reset_chain_data: got %b expected 0", o_chain_data); end
        n_vec++; if (o_chain_clk_en !== 1'b0) begin n_err++; $display("FAIL reset_clk_en: got %b expected 0", o_chain_clk_en); end
        n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        n_vec++; if (o_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", o_done); end
        n_vec++; if (cfg_if.cfg_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b expected 0", cfg_if.cfg_ready); end
        n_vec++; if ((^state_dbg) === 1'bx) begin n_err++; $display("FAIL reset_state_known: got %b expected known", state_dbg); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (o_busy !== 1'b0 || o_chain_rst !== 1'b1) begin n_err++; $display("FAIL idle_hold: got busy=%b chain_rst=%b expected 0/1", o_busy, o_chain_rst); end
    endtask

    task automatic test_basic_load();
        logic [2:0] hdr;
        int d;
        new_words(1'b1);
        build_expected(3'b101);
        drive_load(3'b101, -1, 0, -1, -1);
        hdr = (got_q.size() >= 3) ? {got_q[2], got_q[1], got_q[0]} : 3'bxxx;
        d = first_diff();
        n_vec++; if (first_en_cycle !== 1) begin n_err++; $display("FAIL basic_first_bit_cycle: got %0d expected 1", first_en_cycle); end
        n_vec++; if (hdr !== 3'b101) begin n_err++; $display("FAIL basic_header: got %b expected 101 (bit0 first)", hdr); end
        n_vec++; if (d != -1) begin n_err++; $display("FAIL basic_stream: first bad bit index %0d, got %0d bits expected %0d", d, got_q.size(), exp_q.size()); end
        n_vec++; if (done_cycle != BASE_DONE) begin n_err++; $display("FAIL basic_done_cycle: got %0d expected %0d", done_cycle, BASE_DONE); end
        n_vec++; if (done_count != 1) begin n_err++; $display("FAIL basic_done_count: got %0d expected 1", done_count); end
        n_vec++; if (gap_cycles != 0) begin n_err++; $display("FAIL basic_gaps: got %0d expected 0", gap_cycles); end
        n_vec++; if (words_used != exp_words) begin n_err++; $display("FAIL basic_words: got %0d expected %0d", words_used, exp_words); end
        n_vec++; if (rst_bad != 0 || ready_bad != 0) begin n_err++; $display("FAIL basic_ctrl: got chain_rst_bad=%0d ready_bad=%0d expected 0/0", rst_bad, ready_bad); end
    endtask

    task automatic test_random_loads();
        logic [NT-1:0] m;
        int d;
        for (int it = 0; it < 4; it++) begin
            m = NT'($urandom_range(0, (1 << NT) - 1));
            new_words(1'b0);
            build_expected(m);
            drive_load(m, -1, 0, -1, -1);
            d = first_diff();
            n_vec++; if (d != -1) begin n_err++; $display("FAIL rand_stream[%0d]: mask %b first bad bit %0d, got %0d bits expected %0d", it, m, d, got_q.size(), exp_q.size()); end
            n_vec++; if (done_cycle != BASE_DONE) begin n_err++; $display("FAIL rand_done_cycle[%0d]: got %0d expected %0d", it, done_cycle, BASE_DONE); end
            n_vec++; if (words_used != exp_words) begin n_err++; $display("FAIL rand_words[%0d]: got %0d expected %0d", it, words_used, exp_words); end
        end
    endtask

    task automatic test_stall();
        logic [NT-1:0] m;
        int len, at, d;
        for (int it = 0; it < 2; it++) begin
            m   = (it == 0) ? (NT'($urandom_range(0, (1 << NT) - 1)) | NT'(1)) : '1;
            len = (it == 0) ? 5 : $urandom_range(1, 7);
            at  = (it == 0) ? 20 : $urandom_range(5, 150);
            new_words(1'b0);
            build_expected(m);
            drive_load(m, at, len, -1, -1);
            d = first_diff();
            n_vec++; if (gap_cycles != len) begin n_err++; $display("FAIL stall_gaps[%0d]: got %0d expected %0d", it, gap_cycles, len); end
            n_vec++; if (hold_bad != 0) begin n_err++; $display("FAIL stall_hold[%0d]: got %0d changes expected 0", it, hold_bad); end
            n_vec++; if (d != -1) begin n_err++; $display("FAIL stall_stream[%0d]: first bad bit %0d, got %0d bits expected %0d", it, d, got_q.size(), exp_q.size()); end
            n_vec++; if (done_cycle != BASE_DONE + len) begin n_err++; $display("FAIL stall_done_cycle[%0d]: got %0d expected %0d", it, done_cycle, BASE_DONE + len); end
        end
    endtask

    task automatic test_start_ignored();
        logic [NT-1:0] m;
        int d;
        m = NT'($urandom_range(0, (1 << NT) - 1));
        new_words(1'b0);
        build_expected(m);
        drive_load(m, -1, 0, -1, 40);
        d = first_diff();
        n_vec++; if (d != -1) begin n_err++; $display("FAIL poke_stream: first bad bit %0d, got %0d bits expected %0d", d, got_q.size(), exp_q.size()); end
        n_vec++; if (done_count != 1) begin n_err++; $display("FAIL poke_done_count: got %0d expected 1", done_count); end
        n_vec++; if (done_cycle != BASE_DONE) begin n_err++; $display("FAIL poke_done_cycle: got %0d expected %0d", done_cycle, BASE_DONE); end
        n_vec++; if (o_busy !== 1'b0 || o_chain_rst !== 1'b1) begin n_err++; $display("FAIL poke_no_restart: got busy=%b chain_rst=%b expected 0/1", o_busy, o_chain_rst); end
    endtask

    task automatic test_reset_mid_load();
        logic [NT-1:0] m;
        int d;
        m = NT'($urandom_range(0, (1 << NT) - 1));
        new_words(1'b0);
        build_expected(m);
        drive_load(m, -1, 0, NT + 1 + 70, -1);
        n_vec++; if (rst_seen_bits != NT + 71) begin n_err++; $display("FAIL midrst_bits_before: got %0d expected %0d", rst_seen_bits, NT + 71); end
        n_vec++; if (post_chain_rst !== 1'b1 || post_busy !== 1'b0) begin n_err++; $display("FAIL midrst_idle: got chain_rst=%b busy=%b expected 1/0", post_chain_rst, post_busy); end
        n_vec++; if (post_clk_en !== 1'b0 || post_data !== 1'b0 || post_ready !== 1'b0) begin n_err++; $display("FAIL midrst_outputs: got clk_en=%b data=%b ready=%b expected 0/0/0", post_clk_en, post_data, post_ready); end
        n_vec++; if (done_count != 0 || post_done !== 1'b0) begin n_err++; $display("FAIL midrst_no_done: got %0d pulses expected 0", done_count); end
        m = NT'($urandom_range(0, (1 << NT) - 1));
        new_words(1'b0);
        build_expected(m);
        drive_load(m, -1, 0, -1, -1);
        d = first_diff();
        n_vec++; if (d != -1) begin n_err++; $display("FAIL midrst_replay_stream: first bad bit %0d, got %0d bits expected %0d", d, got_q.size(), exp_q.size()); end
        n_vec++; if (done_cycle != BASE_DONE || done_count != 1) begin n_err++; $display("FAIL midrst_replay_done: got cycle %0d count %0d expected %0d/1", done_cycle, done_count, BASE_DONE); end
    endtask

    task automatic test_sparse_mask();
        int d;
        new_words(1'b0);
        build_expected(3'b010);
        drive_load(3'b010, -1, 0, -1, -1);
        d = first_diff();
        n_vec++; if (words_used != exp_words) begin n_err++; $display("FAIL sparse_words: got %0d expected %0d", words_used, exp_words); end
        n_vec++; if (d != -1) begin n_err++; $display("FAIL sparse_stream: first bad bit %0d, got %0d bits expected %0d", d, got_q.size(), exp_q.size()); end
        n_vec++; if (done_cycle != BASE_DONE) begin n_err++; $display("FAIL sparse_done_cycle: got %0d expected %0d", done_cycle, BASE_DONE); end
        n_vec++; if (ready_bad != 0) begin n_err++; $display("FAIL sparse_ready: got %0d stray ready cycles expected 0", ready_bad); end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_basic_load();
        test_random_loads();
        test_stall();
        test_start_ignored();
        test_reset_mid_load();
        test_sparse_mask();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/jtag_chain_ctrl.md
JTAG_CHAIN_CTRL -- requirements
Module: jtag_chain_ctrl

Interface
REQ-001 Parameters SHALL be: NUM_TILES, default 9, number of tiles on the serial chain; MEM_BITS, default 32768, payload bits per tile window; WORD_W, default 32, configuration word width.
REQ-002 MEM_BITS SHALL be an integer multiple of WORD_W; counter widths SHALL be derived with $clog2.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin one chain load; ignored unless in IDLE.
REQ-006 tile_mask  input  NUM_TILES  per-tile enable, sampled on accepted start.
REQ-007 cfg_data  input  WORD_W  payload word, transmitted MSB first.
REQ-008 cfg_valid  input  1  cfg_data valid.
REQ-009 cfg_ready  output  1  controller accepts cfg_data this cycle (combinational).
REQ-010 chain_rst  output  1  drives tile reset pins; high = tiles hold their counters at zero.
REQ-011 chain_data  output  1  serial bit into tile 0 data_in.
REQ-012 chain_clk_en  output  1  qualifies the tile clock; tiles advance only when high.
REQ-013 busy  output  1  high in HEADER, PAYLOAD, DONE.
REQ-014 done  output  1  one-cycle pulse at end of load.

Function
REQ-015 States SHALL be IDLE, HEADER, PAYLOAD, DONE; all outputs except cfg_ready SHALL be registered.
REQ-016 IDLE: chain_rst=1, chain_clk_en=0, chain_data=0; start=1 latches tile_mask and moves to HEADER.
REQ-017 First header bit SHALL appear on chain_data one cycle after start is accepted, with chain_rst=0 and chain_clk_en=1.
REQ-018 HEADER SHALL last exactly NUM_TILES cycles, emitting mask bit i in header cycle i (i = 0 first), chain_clk_en=1 each cycle, then enter PAYLOAD.
REQ-019 PAYLOAD SHALL emit NUM_TILES*MEM_BITS qualified bits (chain_clk_en=1), tile 0 window first, each word MSB first.
REQ-020 cfg_ready SHALL be high in PAYLOAD when the word in progress has at most one bit left to emit this cycle and payload words remain; never high elsewhere.
REQ-021 A word accepted (cfg_valid && cfg_ready) in cycle t SHALL put its MSB on chain_data in cycle t+1; back-to-back words SHALL give no gap.
REQ-022 If no bit is available (cfg_valid low when needed), controller SHALL drive chain_clk_en=0 and hold chain_data; bit counters SHALL not advance (stall, no data loss).
REQ-023 After the last payload bit, the FSM SHALL enter DONE for one cycle: done=1, chain_clk_en=0, chain_rst=0, then return to IDLE.
REQ-024 start asserted while busy SHALL be ignored; tile_mask changes while busy SHALL have no effect.
REQ-025 Bit and word counters SHALL wrap only at window boundaries; no counter SHALL overflow for default parameters.

Reset
REQ-026 rst=1 SHALL force IDLE within one cycle: chain_rst=1, chain_data=0, chain_clk_en=0, busy=0, done=0, counters and latched mask cleared.
REQ-027 rst mid-load SHALL abort with no done pulse; a partially consumed word SHALL be discarded.

Configuration
REQ-028 Macro JTAG_CHAIN_ZERO_FILL_EN: when defined, windows of tiles with latched mask bit 0 SHALL emit MEM_BITS zeros with chain_clk_en=1 and cfg_ready=0 (no words consumed); when undefined, every window SHALL consume MEM_BITS/WORD_W words regardless of mask.

Verification (NUM_TILES=3, MEM_BITS=64, WORD_W=32)
REQ-029 Reset then start with mask=3'b101, words 0xA5A5A5A5..., cfg_valid always 1 -> header 1,0,1 in cycles 1-3, 192 payload bits contiguous, done at cycle 196.
REQ-030 cfg_valid low for 5 cycles mid-word-boundary -> chain_clk_en=0 for exactly those cycles, chain_data held, no bit lost, done delayed by 5.
REQ-031 start pulsed during PAYLOAD and mask changed -> no restart, header unaffected, single done.
REQ-032 rst asserted at payload bit 70 -> next cycle chain_rst=1, busy=0, no done; fresh start replays full sequence.
REQ-033 JTAG_CHAIN_ZERO_FILL_EN defined, mask=3'b010 -> only 2 words consumed, tile 0 and tile 2 windows all zero, total length unchanged.
